// File: rtl/ps2_scan_receiver.sv
// Purpose: oversample raw PS/2 pins, deserialise 11-bit frames, strip F0/E0 prefixes, strobe one scan code per key event.
// Latency: oValid/oError rise 1 Clock after the synchronised stop-bit fall (about 4 Clocks after the pin edge).
// Backpressure: none; the strobe is one cycle and the consumer must take it. The PS/2 device cannot be stalled.
module ps2_scan_receiver #(
   parameter int TIMEOUT_CYCLES = 5000,
   parameter int TIMER_WIDTH    = 16
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iPS2Clk,
   input  logic       iPS2Data,
   output logic [7:0] oScanCode,
   output logic       oValid,
   output logic       oBreak,
   output logic       oExtended,
   output logic       oError,
   output logic [1:0] oErrCode,
   output logic       oBusy
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_next_state;
   logic                   r_clk_s1, r_clk_s2, r_clk_prev;
   logic                   r_dat_s1, r_dat_s2;
   logic [TIMER_WIDTH-1:0] r_timer;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_shift;
   logic                   r_parity;
   logic                   r_brk_flag, r_ext_flag;
   logic [7:0]             r_code;
   logic                   r_brk_out, r_ext_out;
   logic                   r_valid, r_error;
   logic [1:0]             r_err_code;
   logic                   w_fall, w_timeout, w_par_ok, w_busy;

   // Two-flop synchronisers on both pins plus a history flop on the clock for edge detection.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         r_clk_s1   <= iPS2Clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= iPS2Data;
         r_dat_s2   <= r_dat_s1;
      end
   end

   assign w_fall    = r_clk_prev & ~r_clk_s2;
   assign w_timeout = (r_state != IDLE) && (r_timer == TIMEOUT_LAST);
   // Odd parity: the eight data bits plus the parity bit must XOR to 1.
   assign w_par_ok  = ^{r_shift, r_parity};

   // Watchdog: restarts on every falling edge and rests at zero while idle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         r_timer <= '0;
      else if (w_fall || w_timeout || r_state == IDLE)
         r_timer <= '0;
      else
         r_timer <= r_timer + 1'b1;
   end

   // FSM state register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // FSM next state; a timeout overrides a coincident falling edge.
   always_comb begin
      w_next_state = r_state;
      if (w_timeout)
         w_next_state = IDLE;
      else if (w_fall) begin
         case (r_state)
            IDLE:    if (!r_dat_s2) w_next_state = DATA;
            DATA:    if (r_bit_cnt == 3'd7) w_next_state = PARITY;
            PARITY:  w_next_state = STOP;
            STOP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // FSM outputs.
   always_comb begin
      w_busy = (r_state != IDLE);
   end

   // Frame datapath, prefix tracking and registered result strobes.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_parity   <= 1'b0;
         r_brk_flag <= 1'b0;
         r_ext_flag <= 1'b0;
         r_code     <= 8'h00;
         r_brk_out  <= 1'b0;
         r_ext_out  <= 1'b0;
         r_valid    <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         if (w_timeout) begin
            r_error    <= 1'b1;
            r_err_code <= 2'b11;
            r_brk_flag <= 1'b0;
            r_ext_flag <= 1'b0;
         end else if (w_fall) begin
            case (r_state)
               IDLE: r_bit_cnt <= 3'd0;
               DATA: begin
                  r_shift   <= {r_dat_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               PARITY: r_parity <= r_dat_s2;
               STOP: begin
                  if (!w_par_ok) begin
                     r_error    <= 1'b1;
                     r_err_code <= 2'b01;
                     r_brk_flag <= 1'b0;
                     r_ext_flag <= 1'b0;
                  end else if (!r_dat_s2) begin
                     r_error    <= 1'b1;
                     r_err_code <= 2'b10;
                     r_brk_flag <= 1'b0;
                     r_ext_flag <= 1'b0;
                  end else if (r_shift == 8'hF0) begin
                     r_brk_flag <= 1'b1;
                  end else if (r_shift == 8'hE0) begin
                     r_ext_flag <= 1'b1;
                  end else begin
                     r_valid    <= 1'b1;
                     r_code     <= r_shift;
                     r_brk_out  <= r_brk_flag;
                     r_ext_out  <= r_ext_flag;
                     r_brk_flag <= 1'b0;
                     r_ext_flag <= 1'b0;
                  end
               end
               default: r_bit_cnt <= 3'd0;
            endcase
         end
      end
   end

   assign oScanCode = r_code;
   assign oValid    = r_valid;
   assign oBreak    = r_brk_out;
   assign oExtended = r_ext_out;
   assign oError    = r_error;
   assign oErrCode  = r_err_code;
   assign oBusy     = w_busy;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: scripted key sequences then random frames, errors and aborted frames.
// Expected events are queued by a frame-level key-event model; a monitor compares each strobe.
// Timeout shortened so runs stay short; PS/2 half period is HALF system clocks.
module tb_ps2_scan_receiver;

   localparam int TOUT = 200;
   localparam int HALF = 20;

   typedef struct {
      bit         is_err;
      logic [1:0] errc;
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } exp_t;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       iPS2Clk = 1'b1;
   logic       iPS2Data = 1'b1;
   logic [7:0] oScanCode;
   logic       oValid, oBreak, oExtended, oError, oBusy;
   logic [1:0] oErrCode;

   bit   clk_en = 1'b1;
   int   total = 0;
   int   bad = 0;
   exp_t q[$];

   // Model state: pending prefixes and the last delivered event.
   bit         m_brk = 0, m_ext = 0;
   logic [7:0] m_code = 8'h00;
   logic       m_lbrk = 0, m_lext = 0;

   ps2_scan_receiver #(.TIMEOUT_CYCLES(TOUT), .TIMER_WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset), .iPS2Clk(iPS2Clk), .iPS2Data(iPS2Data),
      .oScanCode(oScanCode), .oValid(oValid), .oBreak(oBreak), .oExtended(oExtended),
      .oError(oError), .oErrCode(oErrCode), .oBusy(oBusy)
   );

   initial begin
      forever begin
         #5;
         if (clk_en) Clock = ~Clock;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic send_bit(input bit b);
      iPS2Data = b;
      wait_clks(HALF);
      iPS2Clk = 1'b0;
      wait_clks(HALF);
      iPS2Clk = 1'b1;
   endtask

   function automatic void push_err(input logic [1:0] ec);
      exp_t e;
      e.is_err = 1; e.errc = ec; e.code = m_code; e.brk = m_lbrk; e.ext = m_lext;
      q.push_back(e);
      m_brk = 0; m_ext = 0;
   endfunction

   // Key-event rules applied to a whole received byte.
   function automatic void model_frame(input logic [7:0] code, input bit par_bad, input bit stop_bad);
      exp_t e;
      if (par_bad) push_err(2'b01);
      else if (stop_bad) push_err(2'b10);
      else if (code == 8'hF0) m_brk = 1;
      else if (code == 8'hE0) m_ext = 1;
      else begin
         m_code = code; m_lbrk = m_brk; m_lext = m_ext;
         e.is_err = 0; e.errc = 2'b00; e.code = code; e.brk = m_brk; e.ext = m_ext;
         q.push_back(e);
         m_brk = 0; m_ext = 0;
      end
   endfunction

   task automatic send_frame(input logic [7:0] code, input bit par_bad, input bit stop_bad, input int gap);
      bit p;
      p = ~(^code) ^ par_bad;
      model_frame(code, par_bad, stop_bad);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(code[i]);
      send_bit(p);
      send_bit(~stop_bad);
      iPS2Data = 1'b1;
      wait_clks(4);
      check("busy_after_frame", oBusy, 0);
      wait_clks(gap);
   endtask

   // Start bit plus nbits of payload, then the clock stays high until the watchdog fires.
   task automatic send_partial(input logic [7:0] code, input int nbits);
      logic [8:0] payload;
      payload = {~(^code), code};
      push_err(2'b11);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(payload[i]);
      wait_clks(HALF);
      check("busy_mid_frame", oBusy, 1);
      iPS2Data = 1'b1;
      wait_clks(TOUT + 100);
      check("busy_after_timeout", oBusy, 0);
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge Clock) begin
      if (!Reset && (oValid || oError)) begin
         if (q.size() == 0) begin
            check("unexpected_strobe", {30'd0, oValid, oError}, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("strobe_exclusive", oValid & oError, 0);
            check("strobe_kind", oError, e.is_err);
            if (e.is_err) check("err_code", oErrCode, e.errc);
            check("scan_code", oScanCode, e.code);
            check("break_flag", oBreak, e.brk);
            check("ext_flag", oExtended, e.ext);
         end
      end
   end

   initial begin
      int r, k;
      wait_clks(3);
      check("rst_code", oScanCode, 0);
      check("rst_valid", oValid, 0);
      check("rst_error", oError, 0);
      check("rst_errcode", oErrCode, 0);
      check("rst_busy", oBusy, 0);
      Reset = 1'b0;
      wait_clks(10);

      send_frame(8'h1D, 0, 0, 10);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h1D, 0, 0, 0);
      send_frame(8'h1B, 0, 0, 10);
      send_frame(8'hE0, 0, 0, 0);
      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'h75, 0, 0, 10);
      send_frame(8'h1D, 1, 0, 5);
      send_frame(8'h1D, 0, 1, 5);
      send_frame(8'h1C, 0, 0, 5);
      send_frame(8'hF0, 0, 0, 0);
      send_partial(8'h55, 4);
      send_frame(8'h23, 0, 0, 5);
      send_frame(8'hE0, 0, 0, 0);

      // Abort a frame after six bits with Reset while Clock is stopped.
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      @(negedge Clock);
      clk_en = 1'b0;
      #20;
      Reset = 1'b1;
      #20;
      check("rst_mid_code", oScanCode, 0);
      check("rst_mid_valid", oValid, 0);
      check("rst_mid_break", oBreak, 0);
      check("rst_mid_ext", oExtended, 0);
      check("rst_mid_error", oError, 0);
      check("rst_mid_errcode", oErrCode, 0);
      check("rst_mid_busy", oBusy, 0);
      iPS2Clk = 1'b1;
      iPS2Data = 1'b1;
      m_brk = 0; m_ext = 0; m_code = 8'h00; m_lbrk = 0; m_lext = 0;
      #20;
      Reset = 1'b0;
      #7;
      clk_en = 1'b1;
      wait_clks(10);
      send_frame(8'h2B, 0, 0, 10);

      for (int n = 0; n < 40; n++) begin
         logic [7:0] code;
         r = $urandom_range(0, 9);
         if (r < 2) code = 8'hF0;
         else if (r < 4) code = 8'hE0;
         else code = 8'($urandom_range(0, 255));
         k = $urandom_range(0, 15);
         if (k == 2) send_partial(code, $urandom_range(0, 9));
         else send_frame(code, k == 0, k == 1, $urandom_range(0, 30));
      end

      wait_clks(50);
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- Front-end stage directly upstream of the keyboard scan-code decoder; sits between the raw PS/2 pins and the logic that moves the on-screen square and changes its colour.
- Oversamples PS2_CLK/PS2_DATA on the system clock and deserialises 11-bit PS/2 frames.
- Checks start, parity and stop bits; strips the F0 (break) and E0 (extended) prefixes.
- Delivers one qualified scan code per key event as a single-cycle strobe in the system clock domain, replacing the decoder's negedge-PS2_CLK clocking.

Parameters:
TIMEOUT_CYCLES, 5000, system clocks without a PS/2 falling edge before a partial frame is aborted (100 us at 50 MHz)
TIMER_WIDTH, 16, width of the watchdog counter; must hold TIMEOUT_CYCLES

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-high reset
iPS2Clk  input  1  raw PS/2 clock pin, asynchronous
iPS2Data  input  1  raw PS/2 data pin, asynchronous
oScanCode  output  8  last delivered scan code, prefixes stripped
oValid  output  1  one-cycle strobe: oScanCode/oBreak/oExtended valid
oBreak  output  1  delivered code was preceded by F0
oExtended  output  1  delivered code was preceded by E0
oError  output  1  one-cycle strobe: frame discarded
oErrCode  output  2  01 parity, 10 stop bit, 11 timeout; held until next oError
oBusy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- One clock: Clock. Reset is asynchronous and active-high. All flops clear immediately on Reset, with no clock needed.
- Reset values: oScanCode=00, oValid=0, oBreak=0, oExtended=0, oError=0, oErrCode=00, oBusy=0, state=IDLE, prefix flags=0, synchronisers=1.
- Both pins pass through a 2-FF synchroniser. A third register provides edge detection.
- fall = (prev sync clk == 1) && (sync clk == 0). Data is sampled from the synchronised data line in the same cycle as fall.
- Frame format: start(0), D0..D7 LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 -> DATA, bit count=0. On fall with data=1 -> stay IDLE (glitch, no error).
  - DATA: on each fall, shift the bit into the shift register MSB, so it is LSB-first. After the 8th bit -> PARITY.
  - PARITY: on fall, store the parity bit -> STOP.
  - STOP: on fall, evaluate the frame -> IDLE.
- Evaluation is done on the stop-bit fall. Outputs are registered and appear the next cycle.
  - Parity check: (^data ^ parity) must be 1, else oError with 01.
  - Stop check: if parity is good and stop=0 -> oError with 10.
  - Good frame with code F0: set break flag; no strobe.
  - Good frame with code E0: set extended flag; no strobe.
  - Any other good code: oScanCode=code, oBreak/oExtended = flags, oValid=1 for one cycle. Both flags clear in the same cycle.
- Any oError clears both prefix flags. oScanCode, oBreak and oExtended hold their last delivered values.
- Watchdog:
  - Counter clears on every fall and while IDLE; otherwise it increments.
  - On reaching TIMEOUT_CYCLES-1 outside IDLE: -> IDLE, oError with 11, prefix flags cleared.
  - A fall in the same cycle as the timeout: the timeout wins, and that edge is dropped.
- oValid and oError are never asserted in the same cycle.
- Minimum spacing between strobes is one full frame.
- Back-to-back frames need no idle gap: the first fall after STOP evaluation is treated as a new start bit.
- Reset mid-frame: the partial frame is discarded, with no strobe after release.

Test Plan:
- Frame 0x1D (bits 0,1,0,1,1,1,0,0,0,P=1,S=1), PS/2 clock period 80 us -> oValid one cycle, oScanCode=1D, oBreak=0, oExtended=0, oBusy low after frame.
- Frames F0 then 1D -> no strobe after F0; single oValid with oScanCode=1D, oBreak=1. Next frame 1B -> oBreak=0.
- Frames E0, F0, 75 -> one oValid, oScanCode=75, oBreak=1, oExtended=1.
- Frame 0x1D with P=0 -> oError, oErrCode=01, no oValid. Same frame with P=1, S=0 -> oErrCode=10. A following clean 0x1C -> oValid, oBreak=0.
- Start bit plus 4 data bits, then clock held high for TIMEOUT_CYCLES -> oError with 11, oBusy=0. Then a full 0x23 frame -> oValid, oScanCode=23.
- Assert Reset after the 6th bit of a frame, release, send 0x2B -> no strobe from the partial frame, oValid with 2B. Also check all outputs are 0 during Reset with Clock stopped.
